// File: rtl/design_2.sv
// Per-frequency cross-spectrum engine: reads each microphone sample A and a per-source
// reference R from BRAM, and writes A*conj(R) at full precision for each frequency bin.
module design_2 #(
    parameter int DATA_WIDTH         = 16,
    parameter int MIC_NUM            = 8,
    parameter int SOR_NUM            = 2,
    parameter int FREQ_NUM           = 257,
    parameter int BRAM_RD_ADDR_WIDTH = 32,
    parameter int BRAM_WR_ADDR_WIDTH = 32,
    parameter int BRAM_WR_WE_WIDTH   = 6,
    parameter int BRAM_RD_INCREASE   = 2,
    parameter int BRAM_WR_INCREASE   = 6,
    parameter int BRAM_RD_ADDR_BASE  = 0,
    parameter int BRAM_WR_ADDR_BASE  = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic signed [DATA_WIDTH-1:0]         af_bram_rd_real,
    input  logic signed [DATA_WIDTH-1:0]         af_bram_rd_imag,
    output logic                                 done,
    output logic                                 all_freq_finish,
    output logic        [BRAM_RD_ADDR_WIDTH-1:0] bram_rd_addr,
    output logic signed [3*DATA_WIDTH-1:0]       result_bram_wr_real,
    output logic signed [3*DATA_WIDTH-1:0]       result_bram_wr_imag,
    output logic        [BRAM_WR_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic        [BRAM_WR_WE_WIDTH-1:0]   bram_wr_we,
    output logic                                 bram_wr_en
);

    localparam int FW = (FREQ_NUM > 1) ? $clog2(FREQ_NUM) : 1;
    localparam int SW = (SOR_NUM > 1) ? $clog2(SOR_NUM) : 1;
    localparam int MW = (MIC_NUM > 1) ? $clog2(MIC_NUM) : 1;
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int OW = 3*DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, RD_REF, RD_ELEM, CALC, WRITE, FIN} state_t;

    state_t          state, next_state;
    logic            ph;
    logic [FW-1:0]   f;
    logic [SW-1:0]   s, s_n;
    logic [MW-1:0]   m, m_n;
    logic            wrap_pend;
    logic            accept, last_m, last_s, last_f;
    logic            cap_ref, cap_elem, calc_en, wr_fire, fin_set;

    logic signed [DATA_WIDTH-1:0] ref_re_p0, ref_im_p0, elem_re_p0, elem_im_p0;
    logic signed [PW-1:0]         prod_re_p1, prod_im_p1;

    function automatic logic [31:0] k_of(input logic [FW-1:0] fi, input logic [SW-1:0] si,
                                         input logic [MW-1:0] mi);
        return 32'(fi) * 32'(MIC_NUM*SOR_NUM) + 32'(si) * 32'(MIC_NUM) + 32'(mi);
    endfunction

    function automatic logic [BRAM_RD_ADDR_WIDTH-1:0] rd_addr_of(input logic [31:0] k);
        return BRAM_RD_ADDR_WIDTH'(BRAM_RD_ADDR_BASE) + BRAM_RD_ADDR_WIDTH'(k * 32'(BRAM_RD_INCREASE));
    endfunction

    function automatic logic [BRAM_WR_ADDR_WIDTH-1:0] wr_addr_of(input logic [31:0] k);
        return BRAM_WR_ADDR_WIDTH'(BRAM_WR_ADDR_BASE) + BRAM_WR_ADDR_WIDTH'(k * 32'(BRAM_WR_INCREASE));
    endfunction

    function automatic logic signed [OW-1:0] sext(input logic signed [PW-1:0] v);
        return OW'(v);
    endfunction

    assign last_m = (m == MW'(MIC_NUM-1));
    assign last_s = (s == SW'(SOR_NUM-1));
    assign last_f = (f == FW'(FREQ_NUM-1));
    // In FIN a start only counts once done is visible, so no start can slip past an unset done.
    assign accept = start && ((state == IDLE) || ((state == FIN) && done));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RD_REF;
            RD_REF:  if (ph) next_state = RD_ELEM;
            RD_ELEM: if (ph) next_state = CALC;
            CALC:    next_state = WRITE;
            WRITE:   next_state = last_m ? (last_s ? FIN : RD_REF) : RD_ELEM;
            FIN:     if (accept) next_state = RD_REF;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cap_ref  = (state == RD_REF) && ph;
        cap_elem = (state == RD_ELEM) && ph;
        calc_en  = (state == CALC);
        wr_fire  = (state == WRITE);
        fin_set  = (state == FIN) && !done;
    end

    always_comb begin
        s_n = s;
        m_n = m;
        if (accept) begin
            s_n = '0;
            m_n = '0;
        end else if (wr_fire) begin
            if (last_m) begin
                m_n = '0;
                s_n = last_s ? '0 : s + 1'b1;
            end else begin
                m_n = m + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph              <= 1'b0;
            f               <= '0;
            s               <= '0;
            m               <= '0;
            wrap_pend       <= 1'b0;
            done            <= 1'b0;
            all_freq_finish <= 1'b0;
            bram_rd_addr    <= BRAM_RD_ADDR_WIDTH'(BRAM_RD_ADDR_BASE);
        end else begin
            ph <= ((state == RD_REF) || (state == RD_ELEM)) ? ~ph : 1'b0;
            s  <= s_n;
            m  <= m_n;
            if (wr_fire && last_m && last_s) begin
                f         <= last_f ? '0 : f + 1'b1;
                wrap_pend <= last_f;
            end
            if (accept) begin
                done            <= 1'b0;
                all_freq_finish <= 1'b0;
            end else if (fin_set) begin
                done            <= 1'b1;
                all_freq_finish <= wrap_pend;
            end
            // Address is loaded on entry so it stays put for both cycles of each read.
            if (next_state == RD_REF)
                bram_rd_addr <= rd_addr_of(k_of(f, s_n, '0));
            else if (next_state == RD_ELEM)
                bram_rd_addr <= rd_addr_of(k_of(f, s_n, m_n));
        end
    end

    // Stage p0: capture at the end of the second read cycle
    always_ff @(posedge clk) begin
        if (cap_ref) begin
            ref_re_p0 <= af_bram_rd_real;
            ref_im_p0 <= af_bram_rd_imag;
        end
        if (cap_elem) begin
            elem_re_p0 <= af_bram_rd_real;
            elem_im_p0 <= af_bram_rd_imag;
        end
    end

    // Stage p1: A * conj(R), exact in PW bits
    always_ff @(posedge clk) begin
        if (calc_en) begin
            prod_re_p1 <= PW'(elem_re_p0) * PW'(ref_re_p0) + PW'(elem_im_p0) * PW'(ref_im_p0);
            prod_im_p1 <= PW'(elem_im_p0) * PW'(ref_re_p0) - PW'(elem_re_p0) * PW'(ref_im_p0);
        end
    end

    // Stage p2: write port, one-cycle strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bram_wr_en          <= 1'b0;
            bram_wr_we          <= '0;
            bram_wr_addr        <= BRAM_WR_ADDR_WIDTH'(BRAM_WR_ADDR_BASE);
            result_bram_wr_real <= '0;
            result_bram_wr_imag <= '0;
        end else begin
            bram_wr_en <= wr_fire;
            bram_wr_we <= wr_fire ? '1 : '0;
            if (wr_fire) begin
                bram_wr_addr        <= wr_addr_of(k_of(f, s, m));
                result_bram_wr_real <= sext(prod_re_p1);
                result_bram_wr_imag <= sext(prod_im_p1);
            end
        end
    end

endmodule

// File: tb/tb_design_2.sv
// Directed bench for design_2: BRAM pattern model, write monitor with a reference model,
// latency, wrap, ignored-start and mid-frequency reset checks.
module tb_design_2;

    `define CHK(TAG, OBS, EXP) begin n_chk++; assert ((OBS) === (EXP)) else begin n_fail++; $error("FAIL %s: observed %0d expected %0d", TAG, (OBS), (EXP)); end end

    localparam int TOTAL = 4112;

    logic               clk = 1'b0;
    logic               rst_n, start;
    logic signed [15:0] af_bram_rd_real, af_bram_rd_imag;
    logic               done, all_freq_finish;
    logic [31:0]        bram_rd_addr, bram_wr_addr;
    logic signed [47:0] result_bram_wr_real, result_bram_wr_imag;
    logic [5:0]         bram_wr_we;
    logic               bram_wr_en;

    int     n_chk = 0, n_fail = 0;
    int     exp_k = 0, freq_writes = 0, first_wr_addr = -1;
    int     wr_cnt [0:TOTAL-1];
    longint log_re [0:TOTAL-1];
    longint log_im [0:TOTAL-1];
    int     lat, bad;

    design_2 dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .af_bram_rd_real(af_bram_rd_real), .af_bram_rd_imag(af_bram_rd_imag),
        .done(done), .all_freq_finish(all_freq_finish), .bram_rd_addr(bram_rd_addr),
        .result_bram_wr_real(result_bram_wr_real), .result_bram_wr_imag(result_bram_wr_imag),
        .bram_wr_addr(bram_wr_addr), .bram_wr_we(bram_wr_we), .bram_wr_en(bram_wr_en)
    );

    always #5 clk = ~clk;

    function automatic logic signed [15:0] mem_re(input int k);
        return 16'((k % 1000) - 500);
    endfunction
    function automatic logic signed [15:0] mem_im(input int k);
        return 16'(((k + 1) % 1000) - 500);
    endfunction
    function automatic longint exp_re(input int k);
        int r = k - (k % 8);
        return longint'(mem_re(k)) * mem_re(r) + longint'(mem_im(k)) * mem_im(r);
    endfunction
    function automatic longint exp_im(input int k);
        int r = k - (k % 8);
        return longint'(mem_im(k)) * mem_re(r) - longint'(mem_re(k)) * mem_im(r);
    endfunction

    // Zero-latency BRAM model
    assign af_bram_rd_real = mem_re(int'(bram_rd_addr >> 1));
    assign af_bram_rd_imag = mem_im(int'(bram_rd_addr >> 1));

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bram_wr_en === 1'b1) begin
                int idx;
                `CHK("wr_addr", bram_wr_addr, 32'(exp_k * 6))
                `CHK("wr_we", bram_wr_we, 6'h3f)
                `CHK("wr_real", result_bram_wr_real, exp_re(exp_k))
                `CHK("wr_imag", result_bram_wr_imag, exp_im(exp_k))
                idx = int'(bram_wr_addr / 6);
                if (idx < TOTAL) begin
                    wr_cnt[idx]++;
                    log_re[idx] = longint'(result_bram_wr_real);
                    log_im[idx] = longint'(result_bram_wr_imag);
                end
                if (freq_writes == 0) first_wr_addr = int'(bram_wr_addr);
                freq_writes++;
                exp_k = (exp_k + 1) % TOTAL;
            end else begin
                `CHK("we_idle", bram_wr_we, 6'h00)
            end
        end
    end

    task automatic check_reset();
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_afin", all_freq_finish, 1'b0)
        `CHK("rst_rd_addr", bram_rd_addr, 32'd0)
        `CHK("rst_wr_addr", bram_wr_addr, 32'd0)
        `CHK("rst_wr_en", bram_wr_en, 1'b0)
        `CHK("rst_wr_we", bram_wr_we, 6'h00)
        `CHK("rst_res_re", result_bram_wr_real, 48'sd0)
        `CHK("rst_res_im", result_bram_wr_imag, 48'sd0)
    endtask

    task automatic run_freq(input bit mid_start, output int l);
        bit got;
        freq_writes   = 0;
        first_wr_addr = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        `CHK("done_fall", done, 1'b0)
        `CHK("afin_clear", all_freq_finish, 1'b0)
        got = 1'b0;
        l = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = (mid_start && (i == 20)) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                l = i;
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        `CHK("done_timeout", got, 1'b1)
    endtask

    initial begin
        logic signed [47:0] neg1;
        neg1 = -48'sd1;
        rst_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < TOTAL; k++) wr_cnt[k] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        run_freq(1'b0, lat);
        `CHK("lat_f0", lat, 69)
        `CHK("writes_f0", freq_writes, 16)
        `CHK("afin_f0", all_freq_finish, 1'b0)
        `CHK("idx0_real", log_re[0], 64'sd499001)
        `CHK("idx0_imag", log_im[0], 64'sd0)
        `CHK("idx1_real", log_re[1], 64'sd498002)
        `CHK("idx1_imag", log_im[1], longint'(neg1))
        repeat (3) @(negedge clk);
        `CHK("done_hold", done, 1'b1)

        run_freq(1'b1, lat);
        `CHK("lat_ignored_start", lat, 69)
        `CHK("writes_ignored_start", freq_writes, 16)

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        freq_writes = 0;
        exp_k = 0;
        for (int k = 0; k < TOTAL; k++) wr_cnt[k] = 0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        `CHK("no_writes_after_rst", freq_writes, 0)
        `CHK("done_after_rst", done, 1'b0)

        for (int i = 0; i < 257; i++) begin
            run_freq(1'b0, lat);
            `CHK("lat_sweep", lat, 69)
            `CHK("writes_sweep", freq_writes, 16)
            `CHK("afin_sweep", all_freq_finish, 1'(i == 256))
            if (i == 0) `CHK("restart_addr", first_wr_addr, 0)
        end
        bad = 0;
        for (int k = 0; k < TOTAL; k++) if (wr_cnt[k] != 1) bad++;
        `CHK("all_written_once", bad, 0)

        run_freq(1'b0, lat);
        `CHK("wrap_first_addr", first_wr_addr, 0)
        `CHK("lat_wrap", lat, 69)
        `CHK("afin_after_wrap", all_freq_finish, 1'b0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
